// File: rtl/dec4_to_bin16.sv
// Packed 4-digit BCD to 16-bit binary converter.
// Converts by repeated weighted addition, one digit unit per clock.
module dec4_to_bin16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] DEC,
  input  logic        st,
  output logic [15:0] BIN,
  output logic [2:0]  ptr_dig,
  output logic        en_conv,
  output logic        ok,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [3:0][3:0]  cnt;
  logic [13:0]      acc;
  logic [13:0]      wgt;
  logic [1:0]       idx;
  logic [3:0]       cur;
  logic             bcd_ok;

  // ptr 4..1 maps onto cnt[3..0]; idx is don't-care when ptr is 0
  assign idx = ptr_dig[1:0] - 2'd1;
  assign cur = cnt[idx];

  assign bcd_ok = (DEC[15:12] <= 4'd9) &&
                  (DEC[11:8]  <= 4'd9) &&
                  (DEC[7:4]   <= 4'd9) &&
                  (DEC[3:0]   <= 4'd9);

  always_comb begin
    wgt = 14'd0;
    unique case (1'b1)
      ptr_dig == 3'd4: wgt = 14'd1000;
      ptr_dig == 3'd3: wgt = 14'd100;
      ptr_dig == 3'd2: wgt = 14'd10;
      ptr_dig == 3'd1: wgt = 14'd1;
      default:         wgt = 14'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      BIN     <= '0;
      ptr_dig <= '0;
      en_conv <= 1'b0;
      ok      <= 1'b0;
      err     <= 1'b0;
    end else if (st) begin
      cnt <= DEC;
      acc <= '0;
      ok  <= 1'b0;
      if (bcd_ok) begin
        state   <= RUN;
        ptr_dig <= 3'd4;
        en_conv <= 1'b1;
        err     <= 1'b0;
      end else begin
        state   <= DONE;
        ptr_dig <= 3'd0;
        en_conv <= 1'b0;
        err     <= 1'b1;
      end
    end else begin
      unique case (state)
        IDLE: begin
          ok <= 1'b0;
        end
        RUN: begin
          if (cur != 4'd0) begin
            acc      <= acc + wgt;
            cnt[idx] <= cur - 4'd1;
          end else if (ptr_dig > 3'd1) begin
            ptr_dig <= ptr_dig - 3'd1;
          end else begin
            state   <= DONE;
            ptr_dig <= 3'd0;
            en_conv <= 1'b0;
          end
        end
        DONE: begin
          ok    <= 1'b1;
          state <= IDLE;
          if (!err)
            BIN <= {2'b00, acc};
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec4_to_bin16.sv
// Directed bench for dec4_to_bin16 with a schedule-based
// reference model compared on every falling edge.
module tb_dec4_to_bin16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DEC;
  logic        st;
  logic [15:0] BIN;
  logic [2:0]  ptr_dig;
  logic        en_conv;
  logic        ok;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  dec4_to_bin16 dut (
    .clk     (clk),
    .rst     (rst),
    .DEC     (DEC),
    .st      (st),
    .BIN     (BIN),
    .ptr_dig (ptr_dig),
    .en_conv (en_conv),
    .ok      (ok),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] p;
    bit         o;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_bin;
  logic [15:0] m_val;
  logic [2:0]  m_ptr;
  logic        m_en;
  logic        m_ok;
  logic        m_err;

  // Expected outputs after every edge are precomputed as a schedule
  // from the digit values when a conversion starts.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_bin = 0; m_val = 0; m_ptr = 0;
      m_en = 0; m_ok = 0; m_err = 0;
    end else if (st) begin
      int d[4];
      bit v;
      ent_t e;
      v = 1;
      for (int i = 0; i < 4; i++) begin
        d[i] = int'(DEC[4*i +: 4]);
        if (d[i] > 9) v = 0;
      end
      q.delete();
      m_ok  = 0;
      m_err = !v;
      m_val = 16'(d[3]*1000 + d[2]*100 + d[1]*10 + d[0]);
      if (v) begin
        m_ptr = 4; m_en = 1;
        for (int p = 4; p >= 1; p--) begin
          for (int k = 0; k < d[p-1]; k++) begin
            e.p = 3'(p); e.o = 0; q.push_back(e);
          end
          e.p = 3'(p-1); e.o = 0; q.push_back(e);
        end
      end else begin
        m_ptr = 0; m_en = 0;
      end
      e.p = 0; e.o = 1; q.push_back(e);
    end else if (q.size() != 0) begin
      ent_t e;
      e = q.pop_front();
      m_ptr = e.p;
      m_en  = (e.p != 0);
      m_ok  = e.o;
      if (e.o && !m_err) m_bin = m_val;
    end else begin
      m_ok = 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("bin", int'(BIN), int'(m_bin));
    chk("ptr", int'(ptr_dig), int'(m_ptr));
    chk("en", int'(en_conv), int'(m_en));
    chk("ok", int'(ok), int'(m_ok));
    chk("err", int'(err), int'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic convert(input logic [15:0] dv, input int hold,
                         input int lat, input int bin,
                         input int e, input string nm);
    int n;
    n = -1;
    DEC = dv;
    st = 1;
    for (int h = 0; h < hold; h++) cyc();
    st = 0;
    for (int k = 1; k <= 80; k++) begin
      cyc();
      if (ok) begin
        n = k;
        break;
      end
    end
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_bin"}, int'(BIN), bin);
    chk({nm, "_err"}, int'(err), e);
    cyc();
  endtask

  initial begin
    int okc;
    logic [14:0] seq;
    logic [2:0]  last;
    rst = 1; st = 0; DEC = 0;
    repeat (2) cyc();
    chk("rst_bin", int'(BIN), 0);
    chk("rst_ptr", int'(ptr_dig), 0);
    chk("rst_ok", int'(ok), 0);
    rst = 0;
    cyc();

    convert(16'h1234, 1, 15, 16'h04D2, 0, "b1234");
    convert(16'h0000, 1, 5, 0, 0, "b0000");

    // full scale with pointer walk capture
    DEC = 16'h9999; st = 1; cyc(); st = 0;
    seq = 15'(ptr_dig); last = ptr_dig; okc = -1;
    for (int k = 1; k <= 80; k++) begin
      cyc();
      if (ptr_dig != last) begin
        seq = {seq[11:0], ptr_dig};
        last = ptr_dig;
      end
      if (ok) begin
        okc = k;
        break;
      end
    end
    chk("f9999_lat", okc, 41);
    chk("f9999_bin", int'(BIN), 16'h270F);
    chk("f9999_seq", int'(seq), int'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
    cyc();

    convert(16'h0042, 1, 11, 42, 0, "b0042");
    convert(16'h12A4, 1, 1, 42, 1, "inv");
    chk("inv_en", int'(en_conv), 0);
    repeat (2) cyc();
    chk("inv_err_hold", int'(err), 1);

    // restart mid-run
    DEC = 16'h9000; st = 1; cyc(); st = 0;
    okc = 0;
    repeat (4) begin
      cyc();
      if (ok) okc++;
    end
    chk("rs_no_ok", okc, 0);
    convert(16'h0007, 1, 12, 7, 0, "rs7");

    convert(16'h0021, 3, 8, 21, 0, "hold");

    // async reset between edges mid-run
    DEC = 16'h5555; st = 1; cyc(); st = 0;
    repeat (6) cyc();
    #3 rst = 1;
    #1;
    chk("ar_bin", int'(BIN), 0);
    chk("ar_ptr", int'(ptr_dig), 0);
    chk("ar_en", int'(en_conv), 0);
    chk("ar_ok", int'(ok), 0);
    chk("ar_err", int'(err), 0);
    @(negedge clk);
    st = 1; DEC = 16'h0009;
    cyc();
    st = 0; rst = 0;
    okc = 0;
    repeat (30) begin
      cyc();
      if (ok) okc++;
    end
    chk("ar_no_ok", okc, 0);
    convert(16'h0001, 1, 6, 1, 0, "ar1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
